dmem_seq: RTL and testbench
===========================

DMEM_SEQ -- requirements
Module: dmem_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, regardless of clk.
REQ-003 acc_valid  input  1  the stage-3 instruction is valid this cycle.
REQ-004 is_load  input  1  the stage-3 instruction is a load.
REQ-005 is_store  input  1  the stage-3 instruction is a store; is_load and is_store are never both 1.
REQ-006 addr  input  32  byte address from the ALU.
REQ-007 wdata  input  32  store data, already lane-shifted.
REQ-008 wmask  input  4  store byte mask.
REQ-009 mem_req_valid  output  1  request to the data cache.
REQ-010 mem_req_ready  input  1  the cache accepts the request.
REQ-011 mem_req_addr  output  30  word address, equal to addr[31:2].
REQ-012 mem_req_data  output  32  store data.
REQ-013 mem_req_wmask  output  4  byte mask; 4'b0000 on a load.
REQ-014 mem_resp_valid  input  1  load response valid.
REQ-015 mem_resp_data  input  32  load response word.
REQ-016 stall  output  1  holds the pipeline.
REQ-017 load_data  output  32  last load word returned.
REQ-018 load_done  output  1  one-cycle pulse when load_data is newly valid.
REQ-019 stall_cnt  output  32  saturating count of stall cycles.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, DONE, encoded in a 2-bit state register.
REQ-021 An access SHALL be defined as acc_valid & (is_load | (is_store & wmask != 0)).
REQ-022 A store with wmask == 0 SHALL be a no-op: no request, no stall, no state change.
REQ-023 IDLE with an access: stall=1 combinationally; addr[31:2], wdata, wmask and is_load captured; next state REQ.
REQ-024 IDLE without an access SHALL keep stall=0 and mem_req_valid=0.
REQ-025 REQ: mem_req_valid=1 and the mem_req_* outputs driven from the captured registers only; stall=1.
REQ-026 REQ with mem_req_ready=1: next state WAIT for a load, DONE for a store; otherwise stay in REQ with the request held stable.
REQ-027 WAIT: stall=1 and mem_req_valid=0; on mem_resp_valid, load_data <= mem_resp_data and next state DONE.
REQ-028 DONE: stall=0 for exactly one cycle, load_done=1 if the captured access was a load, and the inputs are ignored; next state IDLE.
REQ-029 Minimum access latency: store 2 stall cycles (IDLE, REQ) then DONE; load 3 stall cycles (IDLE, REQ, WAIT) then DONE.
REQ-030 mem_resp_valid in IDLE, REQ or DONE SHALL be ignored, with load_data unchanged.
REQ-031 Input changes while in REQ or WAIT SHALL NOT affect the captured request.
REQ-032 load_data SHALL hold its value until the next accepted response.
REQ-033 stall_cnt SHALL increment each cycle stall=1 and saturate at 32'hFFFF_FFFF without wrapping.
REQ-034 mem_req_valid and stall SHALL be glitch-free functions of the state plus, in IDLE only, the access inputs.

Reset
REQ-035 When reset is low, state=IDLE, mem_req_valid=0, and load_data, load_done, stall_cnt and all captured registers are 0.
REQ-036 While reset is low, stall SHALL be 0.
REQ-037 Reset asserted in REQ or WAIT SHALL abort the access immediately, and a later mem_resp_valid for it SHALL be ignored.
REQ-038 After reset releases, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-039 Load, addr=0x0000_1004, ready on first REQ cycle, resp one cycle later with 0xDEAD_BEEF -> mem_req_addr=0x401, 3 stall cycles, load_done pulse, load_data=0xDEADBEEF.
REQ-040 Store, addr=0x10, wdata=0x1234_5678, wmask=4'b0011, ready low 4 cycles -> request held stable 5 cycles, stall 6 cycles, then DONE, no load_done.
REQ-041 Store with wmask=0 -> no mem_req_valid, stall=0, stall_cnt unchanged.
REQ-042 Reset low during WAIT, then resp_valid with 0x5555_5555 after release -> state IDLE, load_data=0, no load_done.
REQ-043 Back-to-back loads in consecutive instructions -> DONE cycle between them has stall=0; second request captured from IDLE the next cycle.
REQ-044 Preload stall_cnt to 0xFFFF_FFFE via stalls or force, then 3 stall cycles -> reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/dmem_seq.sv
// dmem_seq: stage-3 data-memory sequencer that issues one cache request per access
// and stalls the pipeline until the store is accepted or the load response arrives.
module dmem_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        acc_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_done,
    output logic [31:0] stall_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [29:0] cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_mask;
    logic        cap_load;
    logic        access;

    // a store with an empty mask never reaches the cache
    assign access = acc_valid & (is_load | (is_store & (|wmask)));

    always_comb begin
        state_nx = state == IDLE ? (access ? REQ : IDLE) :
                   state == REQ  ? (mem_req_ready ? (cap_load ? WAIT : DONE) : REQ) :
                   state == WAIT ? (mem_resp_valid ? DONE : WAIT) : IDLE;
    end

    // reset gates stall directly because the IDLE term looks at live inputs
    assign stall         = reset & ((state == IDLE & access) | state == REQ | state == WAIT);
    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = cap_addr;
    assign mem_req_data  = cap_data;
    assign mem_req_wmask = cap_mask;
    assign load_done     = state == DONE & cap_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_mask  <= '0;
            cap_load  <= 1'b0;
            load_data <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && access) begin
                cap_addr <= addr[31:2];
                cap_data <= wdata;
                cap_mask <= is_load ? 4'h0 : wmask;
                cap_load <= is_load;
            end
            if (state == WAIT && mem_resp_valid)
                load_data <= mem_resp_data;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_dmem_seq.sv
// tb_dmem_seq: randomized transaction-level check of dmem_seq against a latency/data model.
module tb_dmem_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        acc_valid, is_load, is_store;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic        mem_req_valid, mem_req_ready;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        stall, load_done;
    logic [31:0] load_data, stall_cnt;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_ld, exp_cnt;

    dmem_seq dut (
        .clk(clk), .reset(reset), .acc_valid(acc_valid), .is_load(is_load), .is_store(is_store),
        .addr(addr), .wdata(wdata), .wmask(wmask), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .stall(stall), .load_data(load_data), .load_done(load_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        acc_valid = 1'($urandom);
        is_load   = 1'($urandom);
        is_store  = !is_load;
        addr      = $urandom;
        wdata     = $urandom;
        wmask     = 4'($urandom);
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
        logic [32:0] s;
        s = {1'b0, a} + 33'(n);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic idle();
        step();
        noise();
        acc_valid      = 1'b0;
        mem_req_ready  = 1'($urandom);
        mem_resp_valid = 1'($urandom);
        mem_resp_data  = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 0);
        chk("idle_req_valid", 32'(mem_req_valid), 0);
        chk("idle_load_done", 32'(load_done), 0);
        chk("idle_load_data", load_data, exp_ld);
        chk("idle_cnt", stall_cnt, exp_cnt);
    endtask

    // one instruction: rd extra not-ready REQ cycles, rs extra WAIT cycles before the response
    task automatic do_acc(input bit ld, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input int rd, input int rs, input logic [31:0] rdata);
        logic [31:0] ea;
        logic [31:0] em;
        bit          acc;
        ea  = {2'b00, a[31:2]};
        em  = ld ? 32'h0 : {28'h0, m};
        acc = ld || m != 4'h0;
        step();
        acc_valid = 1'b1; is_load = ld; is_store = !ld; addr = a; wdata = d; wmask = m;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'($urandom);
        mem_resp_data  = $urandom;
        #1;
        chk("first_stall", 32'(stall), 32'(acc));
        chk("first_req_valid", 32'(mem_req_valid), 0);
        if (!acc) begin
            step();
            noise();
            acc_valid = 1'b0;
            #1;
            chk("noop_stall", 32'(stall), 0);
            chk("noop_req_valid", 32'(mem_req_valid), 0);
            chk("noop_cnt", stall_cnt, exp_cnt);
            chk("noop_load_data", load_data, exp_ld);
            return;
        end
        for (int k = 0; k <= rd; k++) begin
            step();
            noise();
            mem_req_ready  = (k == rd);
            mem_resp_valid = 1'($urandom);
            mem_resp_data  = $urandom;
            #1;
            chk("req_valid", 32'(mem_req_valid), 1);
            chk("req_addr", 32'(mem_req_addr), ea);
            chk("req_data", mem_req_data, d);
            chk("req_wmask", 32'(mem_req_wmask), em);
            chk("req_stall", 32'(stall), 1);
            chk("req_load_data", load_data, exp_ld);
        end
        if (ld) begin
            for (int j = 0; j <= rs; j++) begin
                step();
                noise();
                mem_req_ready  = 1'($urandom);
                mem_resp_valid = (j == rs);
                mem_resp_data  = (j == rs) ? rdata : $urandom;
                #1;
                chk("wait_req_valid", 32'(mem_req_valid), 0);
                chk("wait_stall", 32'(stall), 1);
            end
            exp_ld = rdata;
        end
        exp_cnt = sat_add(exp_cnt, 2 + rd + (ld ? rs + 1 : 0));
        step();
        noise();
        mem_req_ready  = 1'($urandom);
        mem_resp_valid = 1'($urandom);
        mem_resp_data  = $urandom;
        #1;
        chk("done_stall", 32'(stall), 0);
        chk("done_req_valid", 32'(mem_req_valid), 0);
        chk("done_load_done", 32'(load_done), 32'(ld));
        chk("done_load_data", load_data, exp_ld);
        chk("done_cnt", stall_cnt, exp_cnt);
    endtask

    initial begin
        reset = 1'b0;
        acc_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        addr = 32'h0000_1004; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA_AAAA;
        exp_ld = 32'h0; exp_cnt = 32'h0;
        #12;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_req_addr", 32'(mem_req_addr), 0);
        chk("rst_req_data", mem_req_data, 0);
        chk("rst_req_wmask", 32'(mem_req_wmask), 0);
        @(negedge clk);
        reset = 1'b1;
        acc_valid = 1'b0;
        idle();

        do_acc(1'b1, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
        idle();
        do_acc(1'b0, 32'h0000_0010, 32'h1234_5678, 4'b0011, 4, 0, 32'h0);
        idle();
        do_acc(1'b0, $urandom, $urandom, 4'h0, 0, 0, 32'h0);
        idle();
        do_acc(1'b1, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D);
        do_acc(1'b1, 32'h0000_2004, 32'h0, 4'h0, 1, 2, 32'hCAFE_0123);
        idle();

        // reset dropped while the load sits in WAIT
        step();
        acc_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; addr = 32'h20;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        step();
        acc_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #1;
        chk("abort_pre_stall", 32'(stall), 1);
        reset = 1'b0;
        #1;
        exp_ld = 32'h0; exp_cnt = 32'h0;
        chk("abort_stall", 32'(stall), 0);
        chk("abort_req_valid", 32'(mem_req_valid), 0);
        chk("abort_load_data", load_data, exp_ld);
        chk("abort_cnt", stall_cnt, exp_cnt);
        @(negedge clk);
        reset = 1'b1;
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555;
        #1;
        chk("late_resp_stall", 32'(stall), 0);
        chk("late_resp_load_done", 32'(load_done), 0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        chk("late_resp_load_data", load_data, exp_ld);
        chk("late_resp_load_done2", 32'(load_done), 0);
        chk("late_resp_req_valid", 32'(mem_req_valid), 0);
        do_acc(1'b0, 32'h44, 32'h0F0F_0F0F, 4'b1000, 0, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] m;
            m = 4'($urandom);
            if ($urandom_range(0, 5) == 0) m = 4'h0;
            do_acc(1'($urandom), $urandom, $urandom, m, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 1) idle();
        end

        step();
        acc_valid = 1'b0;
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        exp_cnt = 32'hFFFF_FFFE;
        #1;
        chk("preload_cnt", stall_cnt, exp_cnt);
        do_acc(1'b1, 32'h0000_3000, 32'h0, 4'h0, 0, 0, 32'h1357_9BDF);
        chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
        do_acc(1'b0, 32'h0000_3004, 32'h2468_ACE0, 4'hF, 2, 0, 32'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
